// File: rtl/hazard_if.sv
// hazard_if: status/control bundle between the pipeline datapath and hazard_ctrl.
//   master : datapath side; drives decode/EX/MEM/WB status, receives stage controls.
//   slave  : hazard_ctrl side; receives status, drives enables, bubble/flush, halt state.
//   Status : id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_load, ex_redirect,
//            imem_stall, dmem_stall, wb_halt
//   Control: pc_en, ifid_en, ifid_flush, idex_en, idex_valid, exmem_en, memwb_en,
//            halted, stall_cycles
interface hazard_if #(
    parameter int unsigned REG_W = 3,
    parameter int unsigned CNT_W = 16
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_load;
    logic             ex_redirect;
    logic             imem_stall;
    logic             dmem_stall;
    logic             wb_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_valid;
    logic             exmem_en;
    logic             memwb_en;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_load, ex_redirect,
               imem_stall, dmem_stall, wb_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_valid, exmem_en, memwb_en,
               halted, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_load, ex_redirect,
               imem_stall, dmem_stall, wb_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_valid, exmem_en, memwb_en,
               halted, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control for the 5-stage core.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : hazard_if.slave; status in (decode regs, EX load/redirect, I/D-mem stalls,
//          WB halt), stage enables / bubble / flush / halted / stall counter out.
// Controls are combinational from state + inputs; state, halted and the saturating
// stall counter are flops.
module hazard_ctrl #(
    parameter int unsigned REG_W = 3,
    parameter int unsigned CNT_W = 16
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave bus
);
    typedef enum logic [1:0] {StRun, StMemWait, StRedirWait, StHalted} state_e;

    state_e           state_q, state_d;
    logic             halted_q, halted_d;
    logic             pend_q, pend_d;     // redirect seen while D-mem froze the pipe
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REG_W-1:0] rs, rt, rd;
    logic             lu, redirect, run_eval;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_valid, exmem_en, memwb_en;

    assign rs = bus.id_rs;
    assign rt = bus.id_rt;
    assign rd = bus.ex_rd;
    assign lu = bus.ex_load & ((bus.id_use_rs & (rs == rd)) | (bus.id_use_rt & (rt == rd)));
    // A redirect held across a D-mem freeze is replayed on release.
    assign redirect = bus.ex_redirect | pend_q;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_valid = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        state_d    = state_q;
        halted_d   = halted_q;
        pend_d     = pend_q;
        run_eval   = 1'b0;

        if (rst) begin
            ifid_flush = 1'b1;
            idex_valid = 1'b0;
        end else begin
            unique case (state_q)
                StRun: run_eval = 1'b1;
                StMemWait: begin
                    if (bus.dmem_stall) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                        pend_d = pend_q | bus.ex_redirect;
                    end else begin
                        run_eval = 1'b1;
                    end
                end
                StRedirWait: begin
                    if (bus.wb_halt) begin
                        run_eval = 1'b1;
                    end else begin
                        // Wrong-path fetch in flight: keep flushing until its word returns.
                        pc_en      = ~bus.imem_stall & ~bus.dmem_stall;
                        ifid_flush = 1'b1;
                        idex_valid = 1'b0;
                        if (bus.dmem_stall) begin
                            exmem_en = 1'b0;
                            memwb_en = 1'b0;
                        end
                        if (!bus.imem_stall && !bus.dmem_stall) state_d = StRun;
                    end
                end
                StHalted: begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                    idex_valid = 1'b0;
                end
                default: state_d = StRun;
            endcase

            if (run_eval) begin
                pend_d  = 1'b0;
                state_d = StRun;
                if (bus.wb_halt) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                    idex_valid = 1'b0;
                    state_d    = StHalted;
                    halted_d   = 1'b1;
                end else if (bus.dmem_stall) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                    pend_d  = redirect;
                    state_d = StMemWait;
                end else if (redirect) begin
                    ifid_flush = 1'b1;
                    idex_valid = 1'b0;
                    if (bus.imem_stall) state_d = StRedirWait;
                end else if (lu) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_valid = 1'b0;
                end else if (bus.imem_stall) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!pc_en && state_q != StHalted && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.ifid_en      = ifid_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_en      = idex_en;
    assign bus.idex_valid   = idex_valid;
    assign bus.exmem_en     = exmem_en;
    assign bus.memwb_en     = memwb_en;
    assign bus.halted       = halted_q & ~rst;
    assign bus.stall_cycles = rst ? '0 : cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Control vector order:
// {pc_en, ifid_en, ifid_flush, idex_en, idex_valid, exmem_en, memwb_en}
module tb_hazard_ctrl;
    localparam int unsigned REG_W = 3;
    localparam int unsigned CNT_W = 4;

    localparam logic [6:0] CNormal = 7'b1101111;
    localparam logic [6:0] CRst    = 7'b1111011;
    localparam logic [6:0] CLu     = 7'b0001011;
    localparam logic [6:0] CFreeze = 7'b0000100;
    localparam logic [6:0] CRedir  = 7'b1111011;
    localparam logic [6:0] CImem   = 7'b0111111;
    localparam logic [6:0] CRwait  = 7'b0111011;
    localparam logic [6:0] CHalt   = 7'b0000000;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    hazard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();
    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [6:0] ctl;
    assign ctl = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_valid,
                  bus.exmem_en, bus.memwb_en};

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.id_rs = 3'd0; bus.id_rt = 3'd0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
        bus.ex_rd = 3'd7; bus.ex_load = 1'b0; bus.ex_redirect = 1'b0;
        bus.imem_stall = 1'b0; bus.dmem_stall = 1'b0; bus.wb_halt = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        rst = 1'b1;
        bus.ex_load = 1'b1; bus.ex_rd = 3'd2; bus.id_rs = 3'd2; bus.id_use_rs = 1'b1;
        bus.dmem_stall = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (ctl !== CRst) begin
            n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, CRst);
        end
        n_cmp++;
        if ({bus.halted, bus.stall_cycles} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state: got halted=%b cnt=%0d want 0/0", bus.halted,
                     bus.stall_cycles);
        end
        rst = 1'b0;
        idle();
        #1;
        n_cmp++;
        if (ctl !== CNormal) begin
            n_fail++; $display("FAIL reset_run: got %b want %b", ctl, CNormal);
        end
    endtask

    task automatic test_load_use;
        do_reset();
        bus.ex_load = 1'b1; bus.ex_rd = 3'd3; bus.id_rs = 3'd3; bus.id_use_rs = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== CLu) begin
            n_fail++; $display("FAIL lu_rs: got %b want %b", ctl, CLu);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (ctl !== CNormal || bus.stall_cycles !== 4'd1) begin
            n_fail++;
            $display("FAIL lu_after: got %b cnt=%0d want %b cnt=1", ctl, bus.stall_cycles,
                     CNormal);
        end
        // rt hit only; rs matches but is not used
        bus.ex_load = 1'b1; bus.ex_rd = 3'd5; bus.id_rs = 3'd5; bus.id_use_rs = 1'b0;
        bus.id_rt = 3'd5; bus.id_use_rt = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== CLu) begin
            n_fail++; $display("FAIL lu_rt: got %b want %b", ctl, CLu);
        end
        bus.id_use_rt = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== CNormal) begin
            n_fail++; $display("FAIL lu_unused: got %b want %b", ctl, CNormal);
        end
        bus.id_use_rt = 1'b1; bus.ex_load = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== CNormal) begin
            n_fail++; $display("FAIL lu_noload: got %b want %b", ctl, CNormal);
        end
        bus.ex_load = 1'b1; bus.id_rt = 3'd4;
        #1;
        n_cmp++;
        if (ctl !== CNormal) begin
            n_fail++; $display("FAIL lu_nomatch: got %b want %b", ctl, CNormal);
        end
        idle();
    endtask

    task automatic test_dmem_stall;
        do_reset();
        bus.dmem_stall = 1'b1;
        // LU and imem_stall lose to the D-mem freeze
        bus.imem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (ctl !== CFreeze) begin
                n_fail++; $display("FAIL dmem_freeze[%0d]: got %b want %b", i, ctl, CFreeze);
            end
            tick();
        end
        idle();
        #1;
        n_cmp++;
        if (ctl !== CNormal || bus.stall_cycles !== 4'd4) begin
            n_fail++;
            $display("FAIL dmem_release: got %b cnt=%0d want %b cnt=4", ctl,
                     bus.stall_cycles, CNormal);
        end
        tick();
        n_cmp++;
        if (bus.stall_cycles !== 4'd4) begin
            n_fail++; $display("FAIL dmem_cnt_hold: got %0d want 4", bus.stall_cycles);
        end
    endtask

    task automatic test_redirect_imem;
        do_reset();
        bus.imem_stall = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== CImem) begin
            n_fail++; $display("FAIL imem_only: got %b want %b", ctl, CImem);
        end
        tick();
        bus.ex_redirect = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== CRedir) begin
            n_fail++; $display("FAIL redir_imem: got %b want %b", ctl, CRedir);
        end
        tick();
        bus.ex_redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (ctl !== CRwait) begin
                n_fail++; $display("FAIL redir_wait[%0d]: got %b want %b", i, ctl, CRwait);
            end
            tick();
        end
        bus.imem_stall = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== CRedir) begin
            n_fail++; $display("FAIL redir_squash: got %b want %b", ctl, CRedir);
        end
        tick();
        n_cmp++;
        if (ctl !== CNormal || bus.stall_cycles !== 4'd4) begin
            n_fail++;
            $display("FAIL redir_done: got %b cnt=%0d want %b cnt=4", ctl, bus.stall_cycles,
                     CNormal);
        end
        // plain redirect, also beats a load-use hit, stays in RUN
        bus.ex_redirect = 1'b1;
        bus.ex_load = 1'b1; bus.ex_rd = 3'd1; bus.id_rs = 3'd1; bus.id_use_rs = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== CRedir) begin
            n_fail++; $display("FAIL redir_plain: got %b want %b", ctl, CRedir);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (ctl !== CNormal) begin
            n_fail++; $display("FAIL redir_plain_after: got %b want %b", ctl, CNormal);
        end
    endtask

    task automatic test_redirect_dmem;
        do_reset();
        bus.ex_redirect = 1'b1; bus.dmem_stall = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== CFreeze) begin
            n_fail++; $display("FAIL rd_dm_freeze: got %b want %b", ctl, CFreeze);
        end
        tick();
        bus.ex_redirect = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== CFreeze) begin
            n_fail++; $display("FAIL rd_dm_hold: got %b want %b", ctl, CFreeze);
        end
        tick();
        bus.dmem_stall = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== CRedir) begin
            n_fail++; $display("FAIL rd_dm_release: got %b want %b", ctl, CRedir);
        end
        tick();
        n_cmp++;
        if (ctl !== CNormal || bus.stall_cycles !== 4'd2) begin
            n_fail++;
            $display("FAIL rd_dm_after: got %b cnt=%0d want %b cnt=2", ctl, bus.stall_cycles,
                     CNormal);
        end
        // reset mid-stall discards the held redirect
        bus.ex_redirect = 1'b1; bus.dmem_stall = 1'b1;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== CNormal || bus.stall_cycles !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_midstall: got %b cnt=%0d want %b cnt=0", ctl,
                     bus.stall_cycles, CNormal);
        end
    endtask

    task automatic test_halt;
        do_reset();
        bus.wb_halt = 1'b1; bus.dmem_stall = 1'b1; bus.ex_redirect = 1'b1;
        bus.ex_load = 1'b1; bus.ex_rd = 3'd6; bus.id_rt = 3'd6; bus.id_use_rt = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== CHalt) begin
            n_fail++; $display("FAIL halt_enter: got %b want %b", ctl, CHalt);
        end
        tick();
        idle();
        bus.imem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (ctl !== CHalt || bus.halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: got %b halted=%b want %b halted=1", i, ctl,
                         bus.halted, CHalt);
            end
            tick();
        end
        n_cmp++;
        if (bus.stall_cycles !== 4'd1) begin
            n_fail++; $display("FAIL halt_cnt: got %0d want 1", bus.stall_cycles);
        end
        do_reset();
        #1;
        n_cmp++;
        if (bus.halted !== 1'b0 || ctl !== CNormal) begin
            n_fail++;
            $display("FAIL halt_exit: got halted=%b %b want 0 %b", bus.halted, ctl, CNormal);
        end
    endtask

    task automatic test_saturate;
        do_reset();
        bus.imem_stall = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        n_cmp++;
        if (bus.stall_cycles !== 4'hE) begin
            n_fail++; $display("FAIL sat_pre: got %0h want e", bus.stall_cycles);
        end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (bus.stall_cycles !== 4'hF) begin
            n_fail++; $display("FAIL sat_hold: got %0h want f", bus.stall_cycles);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_dmem_stall();
        test_redirect_imem();
        test_redirect_dmem();
        test_halt();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
